reset_ctrl: RTL and testbench

Board reset controller, downstream of the watchdog. It consumes the watchdog timeout request, a debounced reset button and a software request, and produces a stretched system reset pulse timed on the shared slow tick `ce`, the same enable that drives the watchdog. Reset causes are latched in a sticky CSR so firmware can read why the board last reset.

---
 rtl/reset_ctrl_pkg.sv | 21 ++
 rtl/reset_ctrl_debounce.sv | 43 ++++
 rtl/reset_ctrl.sv | 114 +++++++++++
 tb/tb_reset_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the board reset controller: CSR map, CAUSE/CTRL bit
// positions and FSM state encoding.
package reset_ctrl_pkg;
  localparam logic [4:0] CSR_CAUSE = 5'h00;
  localparam logic [4:0] CSR_CTRL  = 5'h01;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_BTN = 2;
  localparam int CAUSE_SW  = 3;

  localparam int CTRL_RSTOUT  = 0;
  localparam int CTRL_HOLDOFF = 1;
  localparam int CTRL_WDT_EN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;
endpackage

// File: rtl/reset_ctrl_debounce.sv
// Reset button conditioning: 2-FF synchronizer, tick-counted debounce and a
// one-cycle pulse on each debounced press (stable 1->0).
module debounce #(
  parameter logic [7:0] DEBOUNCE_TICKS = 8'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ce,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       r_stable;
  logic       r_stable_d;
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= 2'b11;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_cnt      <= 8'd0;
    end else begin
      r_sync     <= {r_sync[0], i_btn_n};
      r_stable_d <= r_stable;
      // Any return to the stable level restarts the persistence count.
      if (r_sync[1] == r_stable) begin
        r_cnt <= 8'd0;
      end else if (i_ce) begin
        if (r_cnt == DEBOUNCE_TICKS - 8'd1) begin
          r_stable <= r_sync[1];
          r_cnt    <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign o_level = r_stable;
  assign o_fall  = r_stable_d & ~r_stable;
endmodule

// File: rtl/reset_ctrl.sv
// Board reset controller: merges WDT, button and software requests into a
// ce-timed reset pulse with hold-off, and records causes in a sticky CSR.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter logic [7:0] PULSE_TICKS    = 8'd16,
  parameter logic [7:0] HOLDOFF_TICKS  = 8'd8,
  parameter logic [7:0] DEBOUNCE_TICKS = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce,
  input  logic       wdt_rst,
  input  logic       btn_n,
  output logic       rst_out
);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_rst_out;
  logic [3:0] r_cause;
  logic       r_wdt_en;

  logic       w_btn_fall;
  logic       w_wr_cause, w_wr_ctrl;
  logic [3:0] w_req, w_set, w_clr;

  debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_ce    (ce),
    .i_btn_n (btn_n),
    .o_level (),
    .o_fall  (w_btn_fall)
  );

  assign w_wr_cause = csr_we && (csr_a == CSR_CAUSE);
  assign w_wr_ctrl  = csr_we && (csr_a == CSR_CTRL);

  always_comb begin
    w_req            = 4'b0000;
    w_req[CAUSE_WDT] = wdt_rst & r_wdt_en;
    w_req[CAUSE_BTN] = w_btn_fall;
    w_req[CAUSE_SW]  = w_wr_ctrl & csr_di[0];
  end

  // Requests in hold-off are dropped entirely, including their cause bits.
  assign w_set = (r_state == ST_HOLDOFF) ? 4'b0000 : w_req;
  assign w_clr = w_wr_cause ? csr_di[3:0] : 4'b0000;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = PULSE_TICKS;
        end
      end
      ST_ASSERT: begin
        if (ce) begin
          if (r_cnt == 8'd1) begin
            w_state_nxt = ST_HOLDOFF;
            w_cnt_nxt   = HOLDOFF_TICKS;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (ce) begin
          if (r_cnt == 8'd1) w_state_nxt = ST_IDLE;
          else               w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= PULSE_TICKS;
      r_rst_out <= 1'b1;
      r_cause   <= 4'b0001;
      r_wdt_en  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= (w_state_nxt == ST_ASSERT);
      r_cause   <= (r_cause & ~w_clr) | w_set;
      if (w_wr_ctrl) r_wdt_en <= csr_di[CTRL_WDT_EN];
    end
  end

  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      CSR_CAUSE: csr_do = {4'b0000, r_cause};
      CSR_CTRL: begin
        csr_do[CTRL_WDT_EN]  = r_wdt_en;
        csr_do[CTRL_HOLDOFF] = (r_state == ST_HOLDOFF);
        csr_do[CTRL_RSTOUT]  = r_rst_out;
      end
      default: csr_do = 8'h00;
    endcase
  end

  assign rst_out = r_rst_out;
endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: CSR vector table plus hand sequences for pulse timing,
// hold-off, debounce, overlap and W1C collisions; reads checked via a queue.
module tb_reset_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       csr_we = 1'b0;
  logic       wdt_rst = 1'b0;
  logic       btn_n = 1'b1;
  logic [4:0] csr_a = 5'h0;
  logic [7:0] csr_di = 8'h0;
  logic [7:0] csr_do;
  logic       rst_out;

  reset_ctrl #(
    .PULSE_TICKS(8'd4), .HOLDOFF_TICKS(8'd2), .DEBOUNCE_TICKS(8'd3)
  ) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .ce(ce), .wdt_rst(wdt_rst), .btn_n(btn_n), .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (63) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  end

  // ce_hi: ce ticks seen while the pulse is high; ce_all: every tick; hi_cyc: cycles high.
  int ce_hi = 0, ce_all = 0, hi_cyc = 0;
  always @(posedge clk) begin
    if (ce) ce_all <= ce_all + 1;
    if (ce && rst_out && !rst) ce_hi <= ce_hi + 1;
    if (rst_out) hi_cyc <= hi_cyc + 1;
  end

  int n_chk = 0, n_fail = 0;
  typedef struct { string name; logic [7:0] exp; } exp_t;
  exp_t sb[$];

  typedef struct {
    string name; logic we; logic [4:0] wa; logic [7:0] wd; logic [4:0] ra; logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [7:0] exp);
    exp_t e;
    @(negedge clk);
    csr_a = a;
    e.name = name; e.exp = exp;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk(e.name, int'(csr_do), int'(e.exp));
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic pulse_wdt();
    @(negedge clk);
    wdt_rst = 1'b1;
    @(negedge clk);
    wdt_rst = 1'b0;
  endtask

  task automatic wait_fall(input string name);
    for (int i = 0; i < 1000 && rst_out; i++) @(negedge clk);
    chk(name, int'(rst_out), 0);
  endtask

  task automatic wait_idle(input string name);
    @(negedge clk);
    csr_a = 5'h01;
    #1;
    for (int i = 0; i < 2000 && (csr_do[1:0] != 2'b00); i++) begin
      @(negedge clk);
      #1;
    end
    chk(name, int'(csr_do[1:0]), 0);
  endtask

  int c, h;

  initial begin
    tbl[0] = '{"tbl_cause_por",   1'b0, 5'h00, 8'h00, 5'h00, 8'h01};
    tbl[1] = '{"tbl_ctrl_idle",   1'b0, 5'h00, 8'h00, 5'h01, 8'h80};
    tbl[2] = '{"tbl_unmap2",      1'b0, 5'h00, 8'h00, 5'h02, 8'h00};
    tbl[3] = '{"tbl_unmap31",     1'b0, 5'h00, 8'h00, 5'h1f, 8'h00};
    tbl[4] = '{"tbl_wr_unmap5",   1'b1, 5'h05, 8'hff, 5'h05, 8'h00};
    tbl[5] = '{"tbl_unmap_nochg", 1'b1, 5'h1f, 8'hff, 5'h00, 8'h01};
    tbl[6] = '{"tbl_w1c_zero",    1'b1, 5'h00, 8'h00, 5'h00, 8'h01};
    tbl[7] = '{"tbl_ctrl_nosw",   1'b1, 5'h01, 8'h80, 5'h01, 8'h80};

    // POR
    repeat (5) @(negedge clk);
    chk("por_rst_out", int'(rst_out), 1);
    rd("por_cause_in_rst", 5'h00, 8'h01);
    rd("por_ctrl_in_rst", 5'h01, 8'h81);
    c = ce_hi;
    @(negedge clk);
    rst = 1'b0;
    wait_fall("por_fall");
    chk("por_pulse_ticks", ce_hi - c, 4);
    rd("por_ctrl_holdoff", 5'h01, 8'h82);
    c = ce_all;
    wait_idle("por_idle");
    chk("por_holdoff_ticks", ce_all - c, 2);
    rd("por_ctrl_idle", 5'h01, 8'h80);

    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].name, tbl[i].ra, tbl[i].exp);
    end
    chk("tbl_no_pulse", int'(rst_out), 0);

    // WDT
    pulse_wdt();
    chk("wdt_rise", int'(rst_out), 1);
    c = ce_hi;
    wait_fall("wdt_fall");
    chk("wdt_pulse_ticks", ce_hi - c, 4);
    wait_idle("wdt_idle");
    rd("wdt_cause", 5'h00, 8'h03);
    wr(5'h00, 8'h0f);
    rd("wdt_w1c_all", 5'h00, 8'h00);

    // WDT disabled
    wr(5'h01, 8'h00);
    rd("wdten0_ctrl", 5'h01, 8'h00);
    h = hi_cyc;
    pulse_wdt();
    repeat (20) @(negedge clk);
    chk("wdten0_no_pulse", hi_cyc - h, 0);
    rd("wdten0_cause", 5'h00, 8'h00);
    wr(5'h01, 8'h80);

    // Button bounce then a valid press
    h = hi_cyc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); btn_n = 1'b0;
      repeat (128) @(negedge clk);
      btn_n = 1'b1;
      repeat (100) @(negedge clk);
    end
    chk("btn_bounce_no_pulse", hi_cyc - h, 0);
    rd("btn_bounce_cause", 5'h00, 8'h00);
    @(negedge clk); btn_n = 1'b0;
    for (int i = 0; i < 400 && !rst_out; i++) @(negedge clk);
    chk("btn_press_pulse", int'(rst_out), 1);
    btn_n = 1'b1;
    wait_fall("btn_fall");
    wait_idle("btn_idle");
    rd("btn_cause", 5'h00, 8'h04);
    wr(5'h00, 8'h0f);

    // SW request with WDT overlap in ASSERT, then WDT ignored in HOLDOFF
    wr(5'h01, 8'h81);
    chk("sw_rise", int'(rst_out), 1);
    c = ce_hi;
    repeat (70) @(negedge clk);
    pulse_wdt();
    wait_fall("sw_fall");
    chk("sw_pulse_not_extended", ce_hi - c, 4);
    rd("sw_ctrl_holdoff", 5'h01, 8'h82);
    h = hi_cyc;
    pulse_wdt();
    wait_idle("sw_idle");
    chk("holdoff_wdt_ignored", hi_cyc - h, 0);
    rd("sw_cause", 5'h00, 8'h0a);
    wr(5'h00, 8'h0f);
    rd("sw_cleared", 5'h00, 8'h00);

    // W1C collision: set wins
    @(negedge clk);
    csr_a = 5'h00; csr_di = 8'h02; csr_we = 1'b1; wdt_rst = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; wdt_rst = 1'b0;
    chk("coll_rise", int'(rst_out), 1);
    rd("coll_cause", 5'h00, 8'h02);
    wait_fall("coll_fall");
    wait_idle("coll_idle");

    // rst mid-pulse restarts POR and drops causes
    pulse_wdt();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rd("midrst_cause", 5'h00, 8'h01);
    c = ce_hi;
    rst = 1'b0;
    wait_fall("midrst_fall");
    chk("midrst_pulse_ticks", ce_hi - c, 4);
    wait_idle("midrst_idle");
    rd("midrst_ctrl", 5'h01, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
